fc_layer_sequencer: RTL and testbench

Initiator-side controller for the sequential dot-product processing element (PE) in the FC-layer datapath. It latches one input vector per layer and fetches each weight row and bias from a synchronous weight memory. For each row it drives the PE's flat operand ports, pulses `pe_start` and waits for `pe_done`. It then emits the captured result as one output beat per neuron and pulses `layer_done` after the last row.

---
 rtl/fc_layer_sequencer.sv | 128 ++++++++++++
 tb/tb_fc_layer_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Sequences one FC layer over a dot-product PE: latch the input vector, fetch each weight row, run the PE, emit one beat per neuron.
// Optional ReLU on captured results when FC_SEQ_RELU_EN is defined.
module fc_layer_sequencer #(
  parameter int VECTOR_LENGTH = 16,
  parameter int NUM_OUTPUTS   = 10,
  parameter int W             = 8,
  parameter int ACC_WIDTH     = W + 7,
  parameter int ADDR_W        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [W*VECTOR_LENGTH-1:0]   in_vector_flat,
  output logic                         w_rd_en,
  output logic [ADDR_W-1:0]            w_addr,
  input  logic [W*VECTOR_LENGTH-1:0]   w_row_flat,
  input  logic [W-1:0]                 w_bias,
  output logic                         pe_start,
  output logic [W*VECTOR_LENGTH-1:0]   pe_in_vector_flat,
  output logic [W*VECTOR_LENGTH-1:0]   pe_weight_row_flat,
  output logic [W-1:0]                 pe_bias,
  input  logic [ACC_WIDTH-1:0]         pe_result,
  input  logic                         pe_done,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_index,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic                         busy,
  output logic                         layer_done,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_KICK, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_OUTPUTS - 1);

  state_t                       state, next_state;
  logic [ADDR_W-1:0]            row_q;
  logic [W*VECTOR_LENGTH-1:0]   in_vec_q;
  logic [W*VECTOR_LENGTH-1:0]   row_w_q;
  logic [W-1:0]                 bias_q;
  logic [ACC_WIDTH-1:0]         result_q;
  logic [ACC_WIDTH-1:0]         captured;

`ifdef FC_SEQ_RELU_EN
  assign captured = pe_result[ACC_WIDTH-1] ? '0 : pe_result;
`else
  assign captured = pe_result;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Handshakes: start is a level sampled only in IDLE; pe_start is a one-cycle
  // pulse; pe_done is a level sampled only in WAIT, so a done left high from the
  // previous row cannot be mistaken for the current one.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  next_state = S_LOAD;
      S_LOAD:   next_state = S_KICK;
      S_KICK:   next_state = S_WAIT;
      S_WAIT:   if (pe_done) next_state = S_WRITE;
      S_WRITE:  next_state = (row_q == LAST_ROW) ? S_FINISH : S_FETCH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en    = 1'b0;
    w_addr     = '0;
    pe_start   = 1'b0;
    out_valid  = 1'b0;
    out_index  = '0;
    out_data   = '0;
    layer_done = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_FETCH: begin
        w_rd_en = 1'b1;
        w_addr  = row_q;
      end
      S_KICK:  pe_start = 1'b1;
      S_WRITE: begin
        out_valid = 1'b1;
        out_index = row_q;
        out_data  = result_q;
      end
      S_FINISH: layer_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      in_vec_q <= '0;
      row_w_q  <= '0;
      bias_q   <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          in_vec_q <= in_vector_flat;
          row_q    <= '0;
        end
        S_LOAD: begin
          row_w_q <= w_row_flat;
          bias_q  <= w_bias;
        end
        S_WAIT:  if (pe_done) result_q <= captured;
        S_WRITE: if (row_q != LAST_ROW) row_q <= row_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign pe_in_vector_flat  = in_vec_q;
  assign pe_weight_row_flat = row_w_q;
  assign pe_bias            = bias_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a behavioural PE and a 1-cycle weight memory.
// Cycle numbers are counted with the accepting start edge as cycle 1.
module tb_fc_layer_sequencer;
  localparam int VL   = 4;
  localparam int NO   = 2;
  localparam int W    = 8;
  localparam int ACC  = W + 7;
  localparam int AW   = 4;
  localparam int S_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [W*VL-1:0]   in_vector_flat;
  logic              w_rd_en;
  logic [AW-1:0]     w_addr;
  logic [W*VL-1:0]   w_row_flat;
  logic [W-1:0]      w_bias;
  logic              pe_start;
  logic [W*VL-1:0]   pe_in_vector_flat;
  logic [W*VL-1:0]   pe_weight_row_flat;
  logic [W-1:0]      pe_bias;
  logic [ACC-1:0]    pe_result;
  logic              pe_done;
  logic              out_valid;
  logic [AW-1:0]     out_index;
  logic [ACC-1:0]    out_data;
  logic              busy;
  logic              layer_done;
  logic [2:0]        dbg_state;

  fc_layer_sequencer #(
    .VECTOR_LENGTH(VL), .NUM_OUTPUTS(NO), .W(W), .ACC_WIDTH(ACC), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vector_flat),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_row_flat(w_row_flat), .w_bias(w_bias),
    .pe_start(pe_start), .pe_in_vector_flat(pe_in_vector_flat),
    .pe_weight_row_flat(pe_weight_row_flat), .pe_bias(pe_bias),
    .pe_result(pe_result), .pe_done(pe_done), .out_valid(out_valid),
    .out_index(out_index), .out_data(out_data), .busy(busy),
    .layer_done(layer_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // weight memory model
  logic [W*VL-1:0] mem_row  [0:15];
  logic [W-1:0]    mem_bias [0:15];
  always @(posedge clk) if (w_rd_en) begin
    w_row_flat <= mem_row[w_addr];
    w_bias     <= mem_bias[w_addr];
  end

  // PE model: done rises VL edges after the start edge, held until next start
  function automatic int dot(input logic [W*VL-1:0] a, input logic [W*VL-1:0] b,
                             input logic [W-1:0] bias);
    int s = 32'($signed(bias));
    for (int i = 0; i < VL; i++) s += $signed(a[i*W +: W]) * $signed(b[i*W +: W]);
    return s;
  endfunction

  int pe_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_cnt <= 0; pe_done <= 1'b0; pe_result <= '0;
    end else if (pe_start) begin
      pe_result <= ACC'(dot(pe_in_vector_flat, pe_weight_row_flat, pe_bias));
      pe_cnt    <= VL;
      pe_done   <= 1'b0;
    end else if (pe_cnt != 0) begin
      pe_cnt <= pe_cnt - 1;
      if (pe_cnt == 1) pe_done <= 1'b1;
    end
  end

  // output monitor
  int             beat_cyc[$];
  int             beat_idx[$];
  logic [ACC-1:0] beat_data[$];
  int             done_cyc[$];
  logic [ACC-1:0] exp_q[$];
  always @(negedge clk) begin
    if (out_valid) begin
      beat_cyc.push_back(cyc); beat_idx.push_back(int'(out_index)); beat_data.push_back(out_data);
    end
    if (layer_done) done_cyc.push_back(cyc);
  end

  // scoreboard counters
  int total = 0;
  int bad = 0;
  int acc_cyc;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W*VL-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic int sdata(input logic [ACC-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic clear_mon();
    beat_cyc.delete(); beat_idx.delete(); beat_data.delete(); done_cyc.delete(); exp_q.delete();
  endtask

  // driver: returns at the negedge of cycle 1, start left high if hold
  task automatic run_start(input logic [W*VL-1:0] vec, input bit hold);
    @(negedge clk);
    start = 1'b1;
    in_vector_flat = vec;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check({tag, "_idle_timeout"}, int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic check_beats(input string tag, input int n);
    check({tag, "_beats"}, beat_cyc.size(), n);
    for (int k = 0; k < n && k < beat_cyc.size() && k < exp_q.size(); k++) begin
      check($sformatf("%s_idx%0d", tag, k), beat_idx[k], k % NO);
      check($sformatf("%s_data%0d", tag, k), sdata(beat_data[k]), sdata(exp_q[k]));
    end
  endtask

  int neg_exp;

  initial begin
`ifdef FC_SEQ_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -8;
`endif
    for (int i = 0; i < 16; i++) begin mem_row[i] = '0; mem_bias[i] = '0; end
    w_row_flat = '0; w_bias = '0;
    reset = 1'b0; start = 1'b0; in_vector_flat = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", int'(busy), 0);
    check("rst_w_rd_en", int'(w_rd_en), 0);
    check("rst_pe_start", int'(pe_start), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_layer_done", int'(layer_done), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_pe_vec", int'(pe_in_vector_flat), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic layer
    mem_row[0] = pack4(1, 1, 1, 1); mem_bias[0] = 8'sd0;
    mem_row[1] = pack4(2, 0, 0, 1); mem_bias[1] = -8'sd3;
    clear_mon();
    exp_q.push_back(ACC'(10)); exp_q.push_back(ACC'(3));
    run_start(pack4(1, 2, 3, 4), 1'b0);
    check("basic_fetch_rd_en", int'(w_rd_en), 1);
    check("basic_fetch_addr", int'(w_addr), 0);
    check("basic_busy", int'(busy), 1);
    wait_idle("basic", 100);
    check_beats("basic", 2);
    if (beat_cyc.size() == 2) begin
      check("basic_beat0_cycle", beat_cyc[0] - acc_cyc + 1, 9);
      check("basic_beat1_cycle", beat_cyc[1] - acc_cyc + 1, 18);
    end
    check("basic_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check("basic_done_cycle", done_cyc[0] - acc_cyc + 1, 19);

    // negative row, input change mid-layer, start while busy
    mem_row[1] = pack4(-1, -1, -1, -1); mem_bias[1] = 8'sd2;
    clear_mon();
    exp_q.push_back(ACC'(10)); exp_q.push_back(ACC'(neg_exp));
    run_start(pack4(1, 2, 3, 4), 1'b0);
    @(negedge clk);
    in_vector_flat = '0;
    repeat (3) @(negedge clk);
    check("busy_start_in_wait", int'(dbg_state), S_WAIT);
    check("latched_vector", int'(pe_in_vector_flat), int'(pack4(1, 2, 3, 4)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("neg", 100);
    check_beats("neg", 2);
    check("neg_done_count", done_cyc.size(), 1);

    // reset during row1 WAIT
    clear_mon();
    run_start(pack4(1, 2, 3, 4), 1'b0);
    repeat (13) @(negedge clk);
    check("abort_in_wait", int'(dbg_state), S_WAIT);
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_pe_row", int'(pe_weight_row_flat), 0);
    check("abort_pe_bias", int'(pe_bias), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_beats", beat_cyc.size(), 1);
    check("abort_done_count", done_cyc.size(), 0);
    clear_mon();
    exp_q.push_back(ACC'(10)); exp_q.push_back(ACC'(neg_exp));
    run_start(pack4(1, 2, 3, 4), 1'b0);
    wait_idle("after_abort", 100);
    check_beats("after_abort", 2);
    check("after_abort_done_count", done_cyc.size(), 1);

    // back-to-back layers with start held
    mem_row[1] = pack4(2, 0, 0, 1); mem_bias[1] = -8'sd3;
    clear_mon();
    for (int k = 0; k < 2; k++) begin exp_q.push_back(ACC'(10)); exp_q.push_back(ACC'(3)); end
    run_start(pack4(1, 2, 3, 4), 1'b1);
    for (int i = 0; i < 100 && beat_cyc.size() < 3; i++) @(negedge clk);
    start = 1'b0;
    wait_idle("b2b", 100);
    check_beats("b2b", 4);
    if (beat_cyc.size() >= 3) check("b2b_spacing", beat_cyc[2] - beat_cyc[0], 20);
    check("b2b_done_count", done_cyc.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "bench timed out");
  end
endmodule
